mem_split_unit: RTL and testbench

MEM_SPLIT_UNIT -- requirements
Module: mem_split_unit

---
 rtl/rv32i_types.sv | 62 ++++++
 rtl/mem_lane_align.sv | 73 +++++++
 rtl/mem_split_unit.sv | 209 ++++++++++++++++++++
 tb/tb_mem_split_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
// Shared type definitions for the load/store path:
//   memfnt      - memory function: no-op, load, store
//   memszt      - access size: byte, half, word, double
//   ldextt      - load extension: sign or zero
//   msu_state_e - mem_split_unit FSM states
// Helper functions translate an access size into a byte count and into a
// right-aligned byte-lane mask.
// -----------------------------------------------------------------------------
package rv32i_types;

   typedef enum logic [1:0] {
      MEM_NM = 2'd0,
      MEM_LD = 2'd1,
      MEM_ST = 2'd2
   } memfnt;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } memszt;

   typedef enum logic {
      EXT_SIGN = 1'b0,
      EXT_ZERO = 1'b1
   } ldextt;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      RESP = 2'd3
   } msu_state_e;

   // Number of bytes touched by an access of the given size.
   function automatic logic [3:0] size_bytes(input memszt sz);
      logic [3:0] n;
      case (sz)
         SZ_B:    n = 4'd1;
         SZ_H:    n = 4'd2;
         SZ_W:    n = 4'd4;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

   // (1 << bytes) - 1 for the given size.
   function automatic logic [7:0] size_mask(input memszt sz);
      logic [7:0] m;
      case (sz)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane alignment for mem_split_unit. All outputs are
// computed over a two-word window so that an access straddling a word boundary
// is described by a low half (first access) and a high half (second access).
// Ports:
//   sz_i       - access size
//   ext_i      - load extension (sign / zero)
//   off_i      - byte offset of the access within the first word
//   wdata_i    - right-aligned store data
//   rbuf_i     - {high word, low word} of data returned by memory
//   mask_o     - byte-enable mask over the two-word window
//   wdata_sh_o - store data shifted into its lanes over the two-word window
//   load_o     - right-aligned, truncated and extended load result
// -----------------------------------------------------------------------------
module mem_lane_align
   import rv32i_types::*;
#(
   parameter  int XLEN = 32,
   localparam int NB   = XLEN / 8,
   localparam int OW   = $clog2(NB)
) (
   input  memszt               sz_i,
   input  ldextt               ext_i,
   input  logic [OW-1:0]       off_i,
   input  logic [XLEN-1:0]     wdata_i,
   input  logic [2*XLEN-1:0]   rbuf_i,
   output logic [2*NB-1:0]     mask_o,
   output logic [2*XLEN-1:0]   wdata_sh_o,
   output logic [XLEN-1:0]     load_o
);

   localparam int MW = 2 * NB;
   localparam int DW = 2 * XLEN;

   logic [MW-1:0]   base_mask;
   logic [OW+2:0]   bit_shift;
   logic [XLEN-1:0] shifted;
   logic [6:0]      nbits;
   logic            sign_bit;

   assign base_mask  = MW'(size_mask(sz_i));
   assign bit_shift  = {off_i, 3'b000};
   assign mask_o     = base_mask << off_i;
   assign wdata_sh_o = DW'(wdata_i) << bit_shift;
   // Only the low word of the shifted window can hold loaded bytes.
   assign shifted    = XLEN'(rbuf_i >> bit_shift);
   assign nbits      = {size_bytes(sz_i), 3'b000};

   always_comb begin
      sign_bit = 1'b0;
      case (sz_i)
         SZ_B:    sign_bit = shifted[7];
         SZ_H:    sign_bit = shifted[15];
         SZ_W:    sign_bit = shifted[31];
         default: sign_bit = shifted[XLEN-1];
      endcase
   end

   // Keep the bits covered by the access size, fill the rest with the
   // extension bit.
   always_comb begin
      load_o = '0;
      for (int i = 0; i < XLEN; i++) begin
         if (i < int'(nbits)) begin
            load_o[i] = shifted[i];
         end else begin
            load_o[i] = (ext_i == EXT_SIGN) && sign_bit;
         end
      end
   end

endmodule

// File: rtl/mem_split_unit.sv
// -----------------------------------------------------------------------------
// mem_split_unit
// Accepts one load/store request at a time, issues one or two word-aligned
// memory accesses and returns an aligned, extended load result (or an
// acknowledgement for stores / no-ops).
// Build option: MEM_SPLIT_EN - when defined, accesses that cross a word
//   boundary are performed as two accesses; otherwise they are rejected with
//   rsp_err=1 and no memory traffic.
// Ports:
//   clk, rst_n                    - clock, synchronous active-low reset
//   req_valid/req_ready           - request handshake
//   req_fn/sz/ext/addr/wdata/tag  - request fields
//   mem_read/write/addr/wdata/mbe - memory request, held until mem_resp
//   mem_rdata, mem_resp           - memory completion
//   rsp_valid/ready/data/tag/err  - response handshake and payload
// -----------------------------------------------------------------------------
module mem_split_unit
   import rv32i_types::*;
#(
   parameter  int XLEN  = 32,
   parameter  int TAG_W = 6,
   localparam int NB    = XLEN / 8,
   localparam int OW    = $clog2(NB)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  memfnt             req_fn,
   input  memszt             req_sz,
   input  ldextt             req_ext,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              mem_read,
   output logic              mem_write,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [NB-1:0]     mem_mbe,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_resp,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_data,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_err
);

`ifdef MEM_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   msu_state_e        state_q, state_d;
   memfnt             fn_q;
   memszt             sz_q;
   ldextt             ext_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [TAG_W-1:0]  tag_q;
   logic              split_q;
   logic              err_q;
   logic [XLEN-1:0]   buf_lo_q;
   logic [XLEN-1:0]   buf_hi_q;

   // ---------------------------------------------------------------------
   // Request classification at accept time
   // ---------------------------------------------------------------------
   logic [4:0] req_end;
   logic       req_split;
   logic       req_is_mem;
   logic       req_bad;
   logic       req_err;
   logic       accept;

   assign req_end    = 5'(req_addr[OW-1:0]) + 5'(size_bytes(req_sz));
   assign req_split  = req_end > 5'(NB);
   assign req_is_mem = (req_fn == MEM_LD) || (req_fn == MEM_ST);
   assign req_bad    = ((req_sz == SZ_D) && (XLEN == 32)) || (req_split && !SPLIT_EN);
   // No-op requests never report an error, whatever their size/offset.
   assign req_err    = req_is_mem && req_bad;
   assign accept     = (state_q == IDLE) && req_valid;

   // ---------------------------------------------------------------------
   // Lane alignment
   // ---------------------------------------------------------------------
   logic [2*NB-1:0]   lane_mask;
   logic [2*XLEN-1:0] lane_wdata;
   logic [XLEN-1:0]   lane_load;
   logic [XLEN-1:0]   base_addr;

   mem_lane_align #(
      .XLEN (XLEN)
   ) u_align (
      .sz_i       (sz_q),
      .ext_i      (ext_q),
      .off_i      (addr_q[OW-1:0]),
      .wdata_i    (wdata_q),
      .rbuf_i     ({buf_hi_q, buf_lo_q}),
      .mask_o     (lane_mask),
      .wdata_sh_o (lane_wdata),
      .load_o     (lane_load)
   );

   assign base_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}};

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_mbe   = '0;
      rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = (req_is_mem && !req_bad) ? ACC0 : RESP;
            end
         end
         ACC0: begin
            mem_read  = (fn_q == MEM_LD);
            mem_write = (fn_q == MEM_ST);
            mem_addr  = base_addr;
            mem_wdata = lane_wdata[XLEN-1:0];
            mem_mbe   = lane_mask[NB-1:0];
            if (mem_resp) begin
               state_d = split_q ? ACC1 : RESP;
            end
         end
         ACC1: begin
            mem_read  = (fn_q == MEM_LD);
            mem_write = (fn_q == MEM_ST);
            // Natural XLEN-bit wrap past the top of the address space.
            mem_addr  = base_addr + XLEN'(NB);
            mem_wdata = lane_wdata[2*XLEN-1:XLEN];
            mem_mbe   = lane_mask[2*NB-1:NB];
            if (mem_resp) begin
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Request latch and read buffers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fn_q     <= MEM_NM;
         sz_q     <= SZ_B;
         ext_q    <= EXT_SIGN;
         addr_q   <= '0;
         wdata_q  <= '0;
         tag_q    <= '0;
         split_q  <= 1'b0;
         err_q    <= 1'b0;
         buf_lo_q <= '0;
         buf_hi_q <= '0;
      end else begin
         if (accept) begin
            fn_q    <= req_fn;
            sz_q    <= req_sz;
            ext_q   <= req_ext;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            tag_q   <= req_tag;
            split_q <= req_split;
            err_q   <= req_err;
         end
         if ((state_q == ACC0) && mem_resp) begin
            buf_lo_q <= mem_rdata;
         end
         if ((state_q == ACC1) && mem_resp) begin
            buf_hi_q <= mem_rdata;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Response payload
   // ---------------------------------------------------------------------
   assign rsp_tag  = tag_q;
   assign rsp_err  = (state_q == RESP) && err_q;
   // Only successful loads carry data; stores, no-ops and errors return 0.
   assign rsp_data = ((state_q == RESP) && (fn_q == MEM_LD) && !err_q) ? lane_load : '0;

endmodule

// File: tb/tb_mem_split_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_split_unit
// Directed bench for mem_split_unit at XLEN=32 with hand-computed expected
// values. Expectations for boundary-crossing accesses follow MEM_SPLIT_EN.
// -----------------------------------------------------------------------------
module tb_mem_split_unit;
   import rv32i_types::*;

   localparam int XLEN  = 32;
   localparam int TAG_W = 6;
   localparam int NB    = XLEN / 8;

   logic              clk;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   memfnt             req_fn;
   memszt             req_sz;
   ldextt             req_ext;
   logic [XLEN-1:0]   req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic [TAG_W-1:0]  req_tag;
   logic              mem_read;
   logic              mem_write;
   logic [XLEN-1:0]   mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic [NB-1:0]     mem_mbe;
   logic [XLEN-1:0]   mem_rdata;
   logic              mem_resp;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [XLEN-1:0]   rsp_data;
   logic [TAG_W-1:0]  rsp_tag;
   logic              rsp_err;

   int n_checks = 0;
   int n_pass   = 0;

   mem_split_unit #(
      .XLEN  (XLEN),
      .TAG_W (TAG_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_fn    (req_fn),
      .req_sz    (req_sz),
      .req_ext   (req_ext),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_tag   (req_tag),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_mbe   (mem_mbe),
      .mem_rdata (mem_rdata),
      .mem_resp  (mem_resp),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_tag   (rsp_tag),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end else begin
         n_pass++;
         $display("ok   %s = 0x%0h", tag, act);
      end
   endtask

   // Advance one clock; all stimulus changes and samples happen 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input memfnt fn, input memszt sz, input ldextt ext,
                       input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wd,
                       input logic [TAG_W-1:0] tag);
      req_valid = 1'b1;
      req_fn    = fn;
      req_sz    = sz;
      req_ext   = ext;
      req_addr  = addr;
      req_wdata = wd;
      req_tag   = tag;
      step();
      req_valid = 1'b0;
      req_wdata = '0;
   endtask

   task automatic mem_cycle(input logic [XLEN-1:0] data);
      mem_rdata = data;
      mem_resp  = 1'b1;
      step();
      mem_resp  = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_fn    = MEM_NM;
      req_sz    = SZ_B;
      req_ext   = EXT_SIGN;
      req_addr  = '0;
      req_wdata = '0;
      req_tag   = '0;
      mem_rdata = '0;
      mem_resp  = 1'b0;
      rsp_ready = 1'b0;
      step();
      step();

      // Reset state
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_mem_read",  64'(mem_read),  64'd0);
      check("rst_mem_write", 64'(mem_write), 64'd0);
      check("rst_rsp_data",  64'(rsp_data),  64'd0);
      check("rst_rsp_tag",   64'(rsp_tag),   64'd0);
      check("rst_rsp_err",   64'(rsp_err),   64'd0);
      rst_n = 1'b1;
      step();

      // mem_resp in IDLE is ignored
      mem_cycle(32'h55555555);
      check("idle_resp_ready", 64'(req_ready), 64'd1);
      check("idle_resp_valid", 64'(rsp_valid), 64'd0);

      // lw 0x100
      send(MEM_LD, SZ_W, EXT_SIGN, 32'h100, '0, 6'd1);
      check("lw_mem_read",  64'(mem_read),  64'd1);
      check("lw_mem_write", 64'(mem_write), 64'd0);
      check("lw_addr",      64'(mem_addr),  64'h100);
      check("lw_mbe",       64'(mem_mbe),   64'hF);
      check("lw_req_ready", 64'(req_ready), 64'd0);
      step();
      check("lw_hold_addr", 64'(mem_addr),  64'h100);
      check("lw_no_rsp",    64'(rsp_valid), 64'd0);
      mem_cycle(32'h8899AABB);
      check("lw_rsp_valid", 64'(rsp_valid), 64'd1);
      check("lw_rsp_data",  64'(rsp_data),  64'h8899AABB);
      check("lw_rsp_err",   64'(rsp_err),   64'd0);
      check("lw_rsp_tag",   64'(rsp_tag),   64'd1);
      check("lw_rsp_rd0",   64'(mem_read),  64'd0);
      mem_cycle(32'h12345678);  // ignored in RESP
      check("lw_resp_ign",  64'(rsp_data),  64'h8899AABB);
      finish_rsp();
      check("lw_done_valid", 64'(rsp_valid), 64'd0);
      check("lw_done_ready", 64'(req_ready), 64'd1);

      // lb 0x103 sign-extended
      send(MEM_LD, SZ_B, EXT_SIGN, 32'h103, '0, 6'd2);
      check("lb_addr", 64'(mem_addr), 64'h100);
      check("lb_mbe",  64'(mem_mbe),  64'h8);
      mem_cycle(32'h80123456);
      check("lb_rsp_data", 64'(rsp_data), 64'hFFFFFF80);
      finish_rsp();

      // lbu 0x103 zero-extended; rsp_ready already high completes in one cycle
      send(MEM_LD, SZ_B, EXT_ZERO, 32'h103, '0, 6'd3);
      check("lbu_mbe", 64'(mem_mbe), 64'h8);
      rsp_ready = 1'b1;
      mem_cycle(32'h80123456);
      check("lbu_rsp_data", 64'(rsp_data), 64'h00000080);
      step();
      rsp_ready = 1'b0;
      check("lbu_one_cycle", 64'(rsp_valid), 64'd0);

      // lh 0x102 (aligned to the upper half)
      send(MEM_LD, SZ_H, EXT_SIGN, 32'h102, '0, 6'd4);
      check("lh_mbe", 64'(mem_mbe), 64'hC);
      mem_cycle(32'hBEEF1234);
      check("lh_rsp_data", 64'(rsp_data), 64'hFFFFBEEF);
      finish_rsp();

      // sw 0x204
      send(MEM_ST, SZ_W, EXT_SIGN, 32'h204, 32'hCAFEF00D, 6'd5);
      check("sw_mem_write", 64'(mem_write), 64'd1);
      check("sw_mem_read",  64'(mem_read),  64'd0);
      check("sw_addr",      64'(mem_addr),  64'h204);
      check("sw_wdata",     64'(mem_wdata), 64'hCAFEF00D);
      check("sw_mbe",       64'(mem_mbe),   64'hF);
      mem_cycle(32'hDEADBEEF);
      check("sw_rsp_data",  64'(rsp_data),  64'd0);
      check("sw_rsp_tag",   64'(rsp_tag),   64'd5);
      finish_rsp();

      // no-op request
      send(MEM_NM, SZ_W, EXT_SIGN, 32'h300, '0, 6'd6);
      check("nm_rsp_valid", 64'(rsp_valid), 64'd1);
      check("nm_mem_read",  64'(mem_read),  64'd0);
      check("nm_mem_write", 64'(mem_write), 64'd0);
      check("nm_rsp_err",   64'(rsp_err),   64'd0);
      check("nm_rsp_data",  64'(rsp_data),  64'd0);
      check("nm_rsp_tag",   64'(rsp_tag),   64'd6);
      finish_rsp();

      // size d is illegal at XLEN=32
      send(MEM_LD, SZ_D, EXT_SIGN, 32'h100, '0, 6'd7);
      check("ld_rsp_valid", 64'(rsp_valid), 64'd1);
      check("ld_mem_read",  64'(mem_read),  64'd0);
      check("ld_rsp_err",   64'(rsp_err),   64'd1);
      finish_rsp();

`ifndef MEM_SPLIT_EN
      // lw 0x101 crosses a word: rejected, response held while not ready
      send(MEM_LD, SZ_W, EXT_SIGN, 32'h101, '0, 6'd9);
      check("mis_mem_read", 64'(mem_read),  64'd0);
      check("mis_rsp_err",  64'(rsp_err),   64'd1);
      for (int i = 0; i < 3; i++) begin
         check("mis_hold_valid", 64'(rsp_valid), 64'd1);
         check("mis_hold_tag",   64'(rsp_tag),   64'd9);
         step();
      end
      finish_rsp();
      check("mis_done_valid", 64'(rsp_valid), 64'd0);

      send(MEM_ST, SZ_H, EXT_SIGN, 32'h0FF, 32'hBEEF, 6'd10);
      check("mis_sh_write", 64'(mem_write), 64'd0);
      check("mis_sh_err",   64'(rsp_err),   64'd1);
      finish_rsp();

      // reset during an access abandons it
      send(MEM_LD, SZ_W, EXT_SIGN, 32'h100, '0, 6'd11);
      check("rst_mid_read", 64'(mem_read), 64'd1);
      rst_n = 1'b0;
      step();
      check("rst_mid_rd0",   64'(mem_read),  64'd0);
      check("rst_mid_ready", 64'(req_ready), 64'd1);
      rst_n = 1'b1;
      mem_cycle(32'h11111111);
      for (int i = 0; i < 3; i++) begin
         check("rst_mid_novalid", 64'(rsp_valid), 64'd0);
         step();
      end
`else
      // split lw 0x102
      send(MEM_LD, SZ_W, EXT_SIGN, 32'h102, '0, 6'd12);
      check("slw_addr0", 64'(mem_addr), 64'h100);
      check("slw_mbe0",  64'(mem_mbe),  64'hC);
      check("slw_read0", 64'(mem_read), 64'd1);
      mem_cycle(32'h2211CCDD);
      check("slw_addr1", 64'(mem_addr), 64'h104);
      check("slw_mbe1",  64'(mem_mbe),  64'h3);
      check("slw_read1", 64'(mem_read), 64'd1);
      check("slw_novalid", 64'(rsp_valid), 64'd0);
      mem_cycle(32'hEEFF4433);
      check("slw_rsp_valid", 64'(rsp_valid), 64'd1);
      check("slw_rsp_data",  64'(rsp_data),  64'h44332211);
      check("slw_rsp_err",   64'(rsp_err),   64'd0);
      finish_rsp();

      // split sh 0x0FF
      send(MEM_ST, SZ_H, EXT_SIGN, 32'h0FF, 32'h0000BEEF, 6'd13);
      check("ssh_addr0",  64'(mem_addr),  64'h0FC);
      check("ssh_mbe0",   64'(mem_mbe),   64'h8);
      check("ssh_wdata0", 64'(mem_wdata), 64'hEF000000);
      check("ssh_write0", 64'(mem_write), 64'd1);
      mem_cycle('0);
      check("ssh_addr1",  64'(mem_addr),  64'h100);
      check("ssh_mbe1",   64'(mem_mbe),   64'h1);
      check("ssh_wdata1", 64'(mem_wdata), 64'h000000BE);
      mem_cycle('0);
      check("ssh_rsp_data", 64'(rsp_data), 64'd0);
      check("ssh_rsp_err",  64'(rsp_err),  64'd0);
      finish_rsp();

      // reset during ACC1 abandons the transaction
      send(MEM_LD, SZ_W, EXT_SIGN, 32'h102, '0, 6'd14);
      mem_cycle(32'h2211CCDD);
      check("rst_acc1_addr", 64'(mem_addr), 64'h104);
      rst_n = 1'b0;
      step();
      check("rst_mid_rd0",   64'(mem_read),  64'd0);
      check("rst_mid_ready", 64'(req_ready), 64'd1);
      rst_n = 1'b1;
      mem_cycle(32'h11111111);
      for (int i = 0; i < 3; i++) begin
         check("rst_mid_novalid", 64'(rsp_valid), 64'd0);
         step();
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
